quiz_controller: RTL and testbench

QUIZ_CONTROLLER -- requirements
Module: quiz_controller

---
 rtl/quiz_controller.sv | 269 ++++++++++++++++++++++++++
 tb/tb_quiz_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_controller.sv
// -----------------------------------------------------------------------------
// quiz_controller
//
// Four-player quiz buzzer controller. Player buttons are synchronized and
// edge-detected. A round-control FSM then arbitrates the first press after
// host_start (winner), any press before the start (foul), or countdown expiry
// (timeout). Entering LOCKED or FOUL fires a fixed-length buzzer pulse.
//
// Parameters
//   BEEP_CYCLES  beep pulse length in clk cycles (25-bit)
//   ARM_GUARD    cycles after entering ARMED during which countdown_finish
//                is ignored. This covers the timer's reload latency.
//
// Build option
//   QUIZ_RR_PRIO_EN  when defined, simultaneous presses are resolved
//                    round-robin, starting after the last LOCKED winner.
//                    When undefined, the lowest index wins.
//
// Ports
//   clk               system clock (12 MHz)
//   rst_n             asynchronous active-low reset
//   host_start        single-cycle pulse: arm a round
//   host_clear        single-cycle pulse: back to IDLE from anywhere
//   player_key[3:0]   raw asynchronous buttons, active-high
//   countdown_finish  timer reached 0
//   countdown_en      timer enable (high only in ARMED)
//   winner_valid      high in LOCKED
//   winner_id[1:0]    latched winner index
//   player_led[3:0]   one-hot winner (LOCKED) or fouler (FOUL)
//   timeout           high in TIMEOUT
//   foul              high in FOUL
//   foul_id[1:0]      latched fouler index
//   beep              buzzer drive
//   state[2:0]        FSM state code (debug)
// -----------------------------------------------------------------------------
module quiz_controller #(
    parameter logic [24:0] BEEP_CYCLES = 25'd5_999_999,
    parameter int          ARM_GUARD   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_start,
    input  logic       host_clear,
    input  logic [3:0] player_key,
    input  logic       countdown_finish,
    output logic       countdown_en,
    output logic       winner_valid,
    output logic [1:0] winner_id,
    output logic [3:0] player_led,
    output logic       timeout,
    output logic       foul,
    output logic [1:0] foul_id,
    output logic       beep,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_FOUL    = 3'd4
    } state_t;

    localparam int GW = (ARM_GUARD < 2) ? 1 : $clog2(ARM_GUARD + 1);
    localparam logic [GW-1:0] GUARD_MAX = GW'(ARM_GUARD);

    // ------------------------------------------------------------------
    // Key synchronizer and registered rising-edge detector
    // ------------------------------------------------------------------
    logic [3:0] key_meta_reg;
    logic [3:0] key_sync_reg;
    logic [3:0] key_prev_reg;
    logic [3:0] press_reg;
    logic [1:0] warm_cnt_reg;
    logic       warm_done;

    // Press detection stays blocked until the sync chain and the previous-
    // sample flop hold real key samples. Without this, a key held through
    // reset would look like a 0->1 edge.
    assign warm_done = (warm_cnt_reg == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_reg <= 2'd0;
        end else if (!warm_done) begin
            warm_cnt_reg <= warm_cnt_reg + 2'd1;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                key_meta_reg[gi] <= 1'b0;
                key_sync_reg[gi] <= 1'b0;
                key_prev_reg[gi] <= 1'b0;
                press_reg[gi]    <= 1'b0;
            end else begin
                key_meta_reg[gi] <= player_key[gi];
                key_sync_reg[gi] <= key_meta_reg[gi];
                key_prev_reg[gi] <= key_sync_reg[gi];
                press_reg[gi]    <= warm_done & key_sync_reg[gi] & ~key_prev_reg[gi];
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration among simultaneous presses
    // ------------------------------------------------------------------
    logic       any_press;
    logic [1:0] pick_idx;

    assign any_press = |press_reg;

`ifdef QUIZ_RR_PRIO_EN
    logic [1:0] rr_ptr_reg;
    logic [1:0] cand_idx;

    // Scan from farthest to nearest, so the candidate right after the
    // pointer is assigned last and therefore wins.
    always_comb begin
        pick_idx = 2'd0;
        cand_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand_idx = rr_ptr_reg + 2'(k + 1);
            if (press_reg[cand_idx]) begin
                pick_idx = cand_idx;
            end
        end
    end
`else
    always_comb begin
        pick_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (press_reg[k]) begin
                pick_idx = 2'(k);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Round FSM
    // ------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic [1:0]  winner_id_reg;
    logic [1:0]  winner_id_next;
    logic [1:0]  foul_id_reg;
    logic [1:0]  foul_id_next;
    logic [GW-1:0] guard_cnt_reg;
    logic        guard_ok;
    logic [24:0] beep_cnt_reg;
    logic        beep_reg;
    logic        countdown_en_reg;
    logic        winner_valid_reg;
    logic        timeout_reg;
    logic        foul_reg;
    logic [3:0]  player_led_reg;
    logic        lock_entry;
    logic        foul_entry;

    assign guard_ok = (guard_cnt_reg == GUARD_MAX);

    always_comb begin
        state_next = state_reg;
        if (host_clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_press) begin
                        state_next = ST_FOUL;
                    end else if (host_start) begin
                        state_next = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (any_press) begin
                        state_next = ST_LOCKED;
                    end else if (countdown_finish && guard_ok) begin
                        state_next = ST_TIMEOUT;
                    end
                end
                ST_LOCKED, ST_TIMEOUT, ST_FOUL: state_next = state_reg;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign lock_entry     = (state_reg == ST_ARMED) && (state_next == ST_LOCKED);
    assign foul_entry     = (state_reg == ST_IDLE)  && (state_next == ST_FOUL);
    assign winner_id_next = lock_entry ? pick_idx : winner_id_reg;
    assign foul_id_next   = foul_entry ? pick_idx : foul_id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            winner_id_reg    <= 2'd0;
            foul_id_reg      <= 2'd0;
            guard_cnt_reg    <= '0;
            beep_cnt_reg     <= 25'd0;
            beep_reg         <= 1'b0;
            countdown_en_reg <= 1'b0;
            winner_valid_reg <= 1'b0;
            timeout_reg      <= 1'b0;
            foul_reg         <= 1'b0;
            player_led_reg   <= 4'd0;
        end else begin
            state_reg        <= state_next;
            winner_id_reg    <= winner_id_next;
            foul_id_reg      <= foul_id_next;
            countdown_en_reg <= (state_next == ST_ARMED);
            winner_valid_reg <= (state_next == ST_LOCKED);
            timeout_reg      <= (state_next == ST_TIMEOUT);
            foul_reg         <= (state_next == ST_FOUL);

            case (state_next)
                ST_LOCKED: player_led_reg <= 4'b0001 << winner_id_next;
                ST_FOUL:   player_led_reg <= 4'b0001 << foul_id_next;
                default:   player_led_reg <= 4'd0;
            endcase

            // Guard counter restarts on every entry to ARMED and saturates.
            if (state_next == ST_ARMED && state_reg != ST_ARMED) begin
                guard_cnt_reg <= '0;
            end else if (state_reg == ST_ARMED && !guard_ok) begin
                guard_cnt_reg <= guard_cnt_reg + 1'b1;
            end

            // Beep: the entry cycle counts as the first high cycle, so the
            // counter is loaded with BEEP_CYCLES-1. It stops at 0 and
            // never wraps.
            if (state_next != ST_LOCKED && state_next != ST_FOUL) begin
                beep_reg     <= 1'b0;
                beep_cnt_reg <= 25'd0;
            end else if (lock_entry || foul_entry) begin
                beep_reg     <= (BEEP_CYCLES != 25'd0);
                beep_cnt_reg <= (BEEP_CYCLES != 25'd0) ? BEEP_CYCLES - 25'd1 : 25'd0;
            end else if (beep_cnt_reg != 25'd0) begin
                beep_cnt_reg <= beep_cnt_reg - 25'd1;
            end else begin
                beep_reg <= 1'b0;
            end
        end
    end

`ifdef QUIZ_RR_PRIO_EN
    // Only a real win moves the pointer; fouls leave the rotation alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= 2'd3;
        end else if (lock_entry) begin
            rr_ptr_reg <= pick_idx;
        end
    end
`endif

    assign countdown_en = countdown_en_reg;
    assign winner_valid = winner_valid_reg;
    assign winner_id    = winner_id_reg;
    assign player_led   = player_led_reg;
    assign timeout      = timeout_reg;
    assign foul         = foul_reg;
    assign foul_id      = foul_id_reg;
    assign beep         = beep_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_quiz_controller.sv
// -----------------------------------------------------------------------------
// tb_quiz_controller
//
// Scoreboard bench for quiz_controller. Expected output sets are pushed when
// stimulus is applied and popped and compared once the DUT has had time to
// respond. Uses a short beep so pulse length can be measured.
// -----------------------------------------------------------------------------
module tb_quiz_controller;

    localparam logic [24:0] BEEP = 25'd8;
    localparam int          GUARD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_start = 1'b0;
    logic       host_clear = 1'b0;
    logic [3:0] player_key = 4'd0;
    logic       countdown_finish = 1'b0;
    logic       countdown_en;
    logic       winner_valid;
    logic [1:0] winner_id;
    logic [3:0] player_led;
    logic       timeout;
    logic       foul;
    logic [1:0] foul_id;
    logic       beep;
    logic [2:0] state;

    quiz_controller #(
        .BEEP_CYCLES (BEEP),
        .ARM_GUARD   (GUARD)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .host_start       (host_start),
        .host_clear       (host_clear),
        .player_key       (player_key),
        .countdown_finish (countdown_finish),
        .countdown_en     (countdown_en),
        .winner_valid     (winner_valid),
        .winner_id        (winner_id),
        .player_led       (player_led),
        .timeout          (timeout),
        .foul             (foul),
        .foul_id          (foul_id),
        .beep             (beep),
        .state            (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [1:0] wid;
        logic [1:0] fid;
        logic       bp;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_wid = 2'd0;
    logic [1:0] exp_fid = 2'd0;
    logic [1:0] exp_ptr = 2'd3;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected arbitration result for a set of simultaneous presses.
    function automatic logic [1:0] arb(input logic [3:0] k, input logic [1:0] p);
        logic [1:0] idx;
        arb = 2'd0;
`ifdef QUIZ_RR_PRIO_EN
        for (int j = 4; j >= 1; j--) begin
            idx = p + 2'(j);
            if (k[idx]) arb = idx;
        end
`else
        for (int j = 3; j >= 0; j--) begin
            idx = 2'(j);
            if (k[idx]) arb = idx;
        end
`endif
    endfunction

    task automatic push_exp(input logic [2:0] st, input logic bp);
        exp_t e;
        e.st  = st;
        e.wid = exp_wid;
        e.fid = exp_fid;
        e.bp  = bp;
        sb_q.push_back(e);
    endtask

    task automatic compare_outputs(input string where);
        exp_t e;
        logic [3:0] led_e;
        if (sb_q.size() == 0) begin
            check_value({where, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            led_e = (e.st == 3'd2) ? (4'b0001 << e.wid) :
                    (e.st == 3'd4) ? (4'b0001 << e.fid) : 4'd0;
            $display("[%0t] %s: state=%0d cen=%0b wv=%0b wid=%0d to=%0b foul=%0b fid=%0d led=%b beep=%0b",
                     $time, where, state, countdown_en, winner_valid, winner_id,
                     timeout, foul, foul_id, player_led, beep);
            check_value({where, ".state"},        32'(state),        32'(e.st));
            check_value({where, ".countdown_en"}, 32'(countdown_en), 32'(e.st == 3'd1));
            check_value({where, ".winner_valid"}, 32'(winner_valid), 32'(e.st == 3'd2));
            check_value({where, ".timeout"},      32'(timeout),      32'(e.st == 3'd3));
            check_value({where, ".foul"},         32'(foul),         32'(e.st == 3'd4));
            check_value({where, ".winner_id"},    32'(winner_id),    32'(e.wid));
            check_value({where, ".foul_id"},      32'(foul_id),      32'(e.fid));
            check_value({where, ".player_led"},   32'(player_led),   32'(led_e));
            check_value({where, ".beep"},         32'(beep),         32'(e.bp));
        end
    endtask

    task automatic clear_to_idle(input string where);
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0;
        push_exp(3'd0, 1'b0);
        compare_outputs(where);
    endtask

    task automatic start_round(input string where);
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        push_exp(3'd1, 1'b0);
        compare_outputs(where);
    endtask

    // Press keys in ARMED. The press pulse appears after 3 edges, and the
    // FSM registers LOCKED on the 4th edge.
    task automatic press_in_armed(input logic [3:0] keys, input string where);
        player_key = keys;
        for (int i = 0; i < 3; i++) begin
            tick();
            push_exp(3'd1, 1'b0);
            compare_outputs({where, ".pre"});
        end
        tick();
        exp_wid = arb(keys, exp_ptr);
        exp_ptr = exp_wid;
        push_exp(3'd2, 1'b1);
        compare_outputs(where);
    endtask

    task automatic release_keys();
        player_key = 4'd0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        push_exp(3'd0, 1'b0);
        compare_outputs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        push_exp(3'd0, 1'b0);
        compare_outputs("after_reset");

        // Winner round with beep length measurement
        start_round("start1");
        press_in_armed(4'b0100, "lock_p2");
        n = 1;
        for (int i = 0; i < 40 && beep; i++) begin
            tick();
            if (beep) n++;
        end
        check_value("beep_len", 32'(n), 32'(BEEP));
        player_key = 4'd0;
        push_exp(3'd2, 1'b0);
        compare_outputs("lock_after_beep");
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        push_exp(3'd2, 1'b0);
        compare_outputs("lock_ignores_start");
        release_keys();
        clear_to_idle("clear1");

        // Timeout: early countdown_finish ignored, later one honoured
        start_round("start2");
        countdown_finish = 1'b1;
        tick();
        countdown_finish = 1'b0;
        push_exp(3'd1, 1'b0);
        compare_outputs("guard_ignores_finish");
        for (int i = 0; i < 8; i++) tick();
        countdown_finish = 1'b1;
        tick();
        push_exp(3'd3, 1'b0);
        compare_outputs("timeout");
        countdown_finish = 1'b0;
        host_start = 1'b1;
        player_key = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        host_start = 1'b0;
        push_exp(3'd3, 1'b0);
        compare_outputs("timeout_holds");
        release_keys();
        clear_to_idle("clear2");

        // Foul: press pulse coincides with host_start in IDLE
        player_key = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            push_exp(3'd0, 1'b0);
            compare_outputs("foul_pre");
        end
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        exp_fid = arb(4'b0010, exp_ptr);
        push_exp(3'd4, 1'b1);
        compare_outputs("foul_p1");
        release_keys();
        clear_to_idle("clear3");

        // Player 1 wins, then a simultaneous 1010 press
        start_round("start3");
        press_in_armed(4'b0010, "lock_p1");
        release_keys();
        clear_to_idle("clear4");
        start_round("start4");
        press_in_armed(4'b1010, "lock_1010");
        tick();
        tick();
        push_exp(3'd2, 1'b1);
        compare_outputs("mid_beep");
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0;
        push_exp(3'd0, 1'b0);
        compare_outputs("clear_mid_beep");
        release_keys();

        // Asynchronous reset while ARMED, with a key held through reset
        start_round("start5");
        player_key = 4'b1000;
        #1;
        rst_n = 1'b0;
        #1;
        exp_wid = 2'd0;
        exp_fid = 2'd0;
        exp_ptr = 2'd3;
        push_exp(3'd0, 1'b0);
        compare_outputs("async_reset");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            push_exp(3'd0, 1'b0);
            compare_outputs("held_key_no_press");
        end
        start_round("start6");
        for (int i = 0; i < 3; i++) tick();
        push_exp(3'd1, 1'b0);
        compare_outputs("armed_held_key");
        release_keys();
        clear_to_idle("clear5");

        if (sb_q.size() != 0) check_value("sb_leftover", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
